// File: rtl/sqrt_result_checker.sv
// Sequential shift-add squarer that classifies a candidate integer square root
// as exact-floor, too low or too high. Define SQRT_CHK_ERRCNT_EN to enable the failing-verdict counter.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high;
// in_ready is high only in IDLE, and out_valid with its flags is held until out_ready.
module sqrt_result_checker #(
    parameter int AW = 128,
    parameter int RW = AW / 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_a,
    input  logic [RW-1:0] in_root,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_pass,
    output logic          out_low,
    output logic          out_high,
    output logic [15:0]   err_count,
    output logic [1:0]    dbg_state
);

    localparam int IW = (RW > 1) ? $clog2(RW) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(RW - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SQUARE = 2'd1;
    localparam logic [1:0] S_CMP    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    r_state;
    logic [AW-1:0] r_a;
    logic [AW-1:0] r_acc;
    logic [RW-1:0] r_root;
    logic [IW-1:0] r_idx;
    logic          r_pass;
    logic          r_low;
    logic          r_high;

    logic [AW-1:0] w_addend;
    logic [AW:0]   w_diff;
    logic          w_borrow;
    logic [RW:0]   w_two_root;
    logic          w_low;

    // a < (root+1)^2 is the same as a - root^2 <= 2*root once the borrow is clear.
    assign w_addend   = {{(AW-RW){1'b0}}, r_root} << r_idx;
    assign w_diff     = {1'b0, r_a} - {1'b0, r_acc};
    assign w_borrow   = w_diff[AW];
    assign w_two_root = {r_root, 1'b0};
    assign w_low      = !w_borrow && (w_diff[AW-1:0] > {{(AW-RW-1){1'b0}}, w_two_root});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_acc   <= '0;
            r_root  <= '0;
            r_idx   <= '0;
            r_pass  <= 1'b0;
            r_low   <= 1'b0;
            r_high  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_root  <= in_root;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= S_SQUARE;
                    end
                end
                S_SQUARE: begin
                    if (r_root[r_idx]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_high  <= w_borrow;
                    r_low   <= w_low;
                    r_pass  <= !w_borrow && !w_low;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // Flags drop with out_valid so they read 0 outside DONE.
                    if (out_ready) begin
                        r_pass  <= 1'b0;
                        r_low   <= 1'b0;
                        r_high  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_pass  = r_pass;
    assign out_low   = r_low;
    assign out_high  = r_high;
    assign dbg_state = r_state;

`ifdef SQRT_CHK_ERRCNT_EN
    logic [15:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= 16'h0000;
        end else if ((r_state == S_DONE) && out_ready && !r_pass && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'h0001;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_sqrt_result_checker.sv
// Self-checking bench for sqrt_result_checker: vector table, latency, backpressure,
// reset mid-operation and busy-hold sequences, with an expected-verdict queue.
module tb_sqrt_result_checker;

  localparam int AW = 128;
  localparam int RW = 64;
  localparam int LAT = RW + 1;
  localparam int BOUND = 300;
  localparam logic [2:0] V_PASS = 3'b100;
  localparam logic [2:0] V_LOW  = 3'b010;
  localparam logic [2:0] V_HIGH = 3'b001;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SQUARE = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [AW-1:0] in_a = '0;
  logic [RW-1:0] in_root = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic out_pass, out_low, out_high;
  logic [15:0] err_count;
  logic [1:0] dbg_state;

  sqrt_result_checker #(.AW(AW), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_root(in_root),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pass(out_pass), .out_low(out_low), .out_high(out_high),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic [AW-1:0] a;
    logic [RW-1:0] r;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[11];
  logic [2:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer a pair and wait for the accept edge; returns #1 after that edge.
  task automatic drive_accept(input logic [AW-1:0] a, input logic [RW-1:0] r,
                              input logic [2:0] exp, input bit push, input bit keep_valid);
    int n = 0;
    in_a = a;
    in_root = r;
    in_valid = 1'b1;
    while (!in_ready && n < BOUND) begin
      @(posedge clk); #1; n++;
    end
    check("accept_timeout", 128'(n < BOUND), 128'd1);
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
    if (push) exp_q.push_back(exp);
  endtask

  task automatic wait_verdict(output int lat);
    lat = 0;
    while (!out_valid && lat < BOUND) begin
      @(posedge clk); #1; lat++;
    end
    check("verdict_timeout", 128'(lat < BOUND), 128'd1);
  endtask

  // Compare the held verdict with the queue head, then take it with out_ready=1.
  task automatic check_and_handshake(input string name);
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 128'(exp_q.size()), 128'd1);
      e = 3'b000;
    end else begin
      e = exp_q.pop_front();
    end
    check({name, "_flags"}, 128'({out_pass, out_low, out_high}), 128'(e));
    out_ready = 1'b1;
    @(posedge clk); #1;
`ifdef SQRT_CHK_ERRCNT_EN
    if (e != V_PASS) exp_err++;
`endif
    check({name, "_err_count"}, 128'(err_count), 128'(exp_err));
    check({name, "_after_hs"}, 128'({out_valid, out_pass, out_low, out_high, in_ready}), 128'(5'b00001));
  endtask

  initial begin
    int lat;
    int seen;
    logic [AW-1:0] rr;

    vecs[0] = '{"zero",      128'd0,   64'd0,  V_PASS};
    vecs[1] = '{"exact_144", 128'd144, 64'd12, V_PASS};
    vecs[2] = '{"floor_168", 128'd168, 64'd12, V_PASS};
    vecs[3] = '{"max",       '1,       '1,     V_PASS};
    vecs[4] = '{"low_169",   128'd169, 64'd12, V_LOW};
    vecs[5] = '{"high_143",  128'd143, 64'd12, V_HIGH};
    vecs[6] = '{"rnd_pass",  '0, {$urandom, $urandom}, V_PASS};
    rr = 128'(vecs[6].r);
    vecs[6].a = rr * rr + ({96'd0, $urandom} % (2 * rr + 128'd1));
    vecs[7] = '{"rnd_low",   '0, {$urandom, $urandom}, V_LOW};
    vecs[7].r[63] = 1'b0;
    rr = 128'(vecs[7].r);
    vecs[7].a = rr * rr + 2 * rr + 128'd1 + 128'($urandom_range(0, 100));
    vecs[8] = '{"rnd_high",  '0, {$urandom, $urandom}, V_HIGH};
    vecs[8].r[40] = 1'b1;
    rr = 128'(vecs[8].r);
    vecs[8].a = rr * rr - 128'd1 - 128'($urandom_range(0, 1000));
    vecs[9]  = '{"edge_2r",   128'd3, 64'd1, V_PASS};
    vecs[10] = '{"edge_2r1",  128'd4, 64'd1, V_LOW};

    // Reset held 3 cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_flags", 128'({out_pass, out_low, out_high}), 128'd0);
    check("rst_err_count", 128'(err_count), 128'd0);
    check("rst_state", 128'(dbg_state), 128'(ST_IDLE));

    // Table of exact, floor, wrong and boundary roots with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive_accept(vecs[i].a, vecs[i].r, vecs[i].exp, 1'b1, 1'b0);
      wait_verdict(lat);
      check({vecs[i].name, "_latency"}, 128'(lat), 128'(LAT));
      check_and_handshake(vecs[i].name);
    end

    // Backpressure: verdict held for 20 cycles with out_ready low.
    out_ready = 1'b0;
    drive_accept(128'd144, 64'd12, V_PASS, 1'b1, 1'b0);
    wait_verdict(lat);
    for (int c = 0; c < 20; c++) begin
      check("bp_hold", 128'({out_valid, out_pass, out_low, out_high, in_ready}), 128'(5'b11000));
      @(posedge clk); #1;
    end
    check_and_handshake("bp");

    // Reset 10 cycles into SQUARE discards the pair.
    out_ready = 1'b1;
    drive_accept(128'd169, 64'd12, V_LOW, 1'b0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    check("mid_state_square", 128'(dbg_state), 128'(ST_SQUARE));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_err = 0;
    check("mid_rst_state", 128'(dbg_state), 128'(ST_IDLE));
    check("mid_rst_in_ready", 128'(in_ready), 128'd1);
    check("mid_rst_err_count", 128'(err_count), 128'd0);
    seen = 0;
    for (int c = 0; c < LAT + 10; c++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("mid_rst_no_verdict", 128'(seen), 128'd0);
    drive_accept(128'd25, 64'd5, V_PASS, 1'b1, 1'b0);
    wait_verdict(lat);
    check("after_rst_latency", 128'(lat), 128'(LAT));
    check_and_handshake("after_rst");

    // Busy hold: in_valid stays high and in_root changes after the accept.
    out_ready = 1'b0;
    drive_accept(128'd144, 64'd12, V_PASS, 1'b1, 1'b1);
    in_root = 64'd13;
    wait_verdict(lat);
    check("busy_latency", 128'(lat), 128'(LAT));
    repeat (5) begin @(posedge clk); #1; end
    check("busy_state_done", 128'({dbg_state, in_ready}), 128'({ST_DONE, 1'b0}));
    check_and_handshake("busy_first");
    @(posedge clk); #1;
    check("busy_second_accept", 128'(dbg_state), 128'(ST_SQUARE));
    in_valid = 1'b0;
    exp_q.push_back(V_HIGH);
    wait_verdict(lat);
    check("busy_second_latency", 128'(lat), 128'(LAT));
    check_and_handshake("busy_second");

    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
